// File: rtl/mips_prog_pkg.sv
// Shared definitions for the MIPS program loader: loader states and word geometry.
// Imported by the loader, its byte assembler and the MIPS top.
package mips_prog_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_COMMIT,
        ST_BOOT,
        ST_RUN
    } ld_state_e;

    function automatic int bpw(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/prog_word_asm.sv
// Big-endian word assembler: shifts bytes in MSB-first and flags the last byte.
// word_out already includes the byte being accepted so the caller can latch it.
module prog_word_asm
    import mips_prog_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [7:0]        byte_in,
    input  logic              byte_en,
    output logic [DATA_W-1:0] word_out,
    output logic              word_done
);

    localparam int BPW = bpw(DATA_W);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    always_comb begin
        word_out  = (shift_q << 8) | DATA_W'(byte_in);
        word_done = byte_en && (cnt_q == CW'(BPW - 1));
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_en) begin
            shift_d = word_out;
            cnt_d   = word_done ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_prog_loader.sv
// Byte-stream boot loader: header word count, big-endian words written to
// program memory 0..N-1, then a core reset pulse in run mode.
module mips_prog_loader
    import mips_prog_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              ProgMode,
    output logic [ADDR_W-1:0] Addr_Prog,
    output logic [DATA_W-1:0] Data_Prog,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int BW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [BW-1:0]     boot_q, boot_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic              err_q, err_d;

    logic              asm_en;
    logic              asm_clr;
    logic              tmo;
    logic              word_done;
    logic [DATA_W-1:0] word;
    logic [ADDR_W:0]   n_hdr;

    assign rx_ready = (state_q == ST_HDR) || (state_q == ST_LOAD);
    assign asm_en   = (state_q == ST_LOAD) && rx_valid && !load_req;
    assign tmo      = (TIMEOUT != 0) && (state_q == ST_LOAD) && !rx_valid
                      && (idle_q == TW'(TIMEOUT - 1));
    assign asm_clr  = (state_q == ST_HDR) || load_req || tmo;

    prog_word_asm #(.DATA_W(DATA_W)) u_asm (
        .clk      (clk),
        .reset    (reset),
        .clr      (asm_clr),
        .byte_in  (rx_data),
        .byte_en  (asm_en),
        .word_out (word),
        .word_done(word_done)
    );

    // A zero header means a full 256-word image on the 8-bit address map
    always_comb begin
        n_hdr = (ADDR_W + 1)'(rx_data);
        if (ADDR_W == 8 && rx_data == 8'd0) begin
            n_hdr = (ADDR_W + 1)'(1) << ADDR_W;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wl_d    = wl_q;
        n_d     = n_q;
        boot_d  = boot_q;
        idle_d  = idle_q;
        err_d   = err_q;
        if (load_req) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_HDR;
                ST_HDR: begin
                    if (rx_valid) begin
                        n_d     = n_hdr;
                        wl_d    = '0;
                        idle_d  = '0;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (rx_valid) begin
                        idle_d = '0;
                        if (word_done) begin
                            addr_d  = wl_q[ADDR_W-1:0];
                            data_d  = word;
                            state_d = ST_COMMIT;
                        end
                    end else if (tmo) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (TIMEOUT != 0) begin
                        idle_d = idle_q + TW'(1);
                    end
                end
                ST_COMMIT: begin
                    wl_d = wl_q + (ADDR_W + 1)'(1);
                    if (wl_q + (ADDR_W + 1)'(1) == n_q) begin
                        boot_d  = '0;
                        state_d = ST_BOOT;
                    end else begin
                        idle_d  = '0;
                        state_d = ST_LOAD;
                    end
                end
                ST_BOOT: begin
                    if (boot_q == BW'(RST_CYCLES - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        boot_d = boot_q + BW'(1);
                    end
                end
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wl_q    <= '0;
            n_q     <= '0;
            boot_q  <= '0;
            idle_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wl_q    <= wl_d;
            n_q     <= n_d;
            boot_q  <= boot_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
        end
    end

    assign ProgMode     = (state_q == ST_BOOT) || (state_q == ST_RUN);
    assign core_reset   = (state_q == ST_IDLE) || (state_q == ST_BOOT);
    assign busy         = (state_q == ST_HDR) || (state_q == ST_LOAD)
                          || (state_q == ST_COMMIT) || (state_q == ST_BOOT);
    assign done         = (state_q == ST_RUN);
    assign err          = err_q;
    assign Addr_Prog    = addr_q;
    assign Data_Prog    = data_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: load, throttled load, timeout,
// reload, mid-load reset and a full 256-word image.
module tb_mips_prog_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        load_req;
    logic        ProgMode;
    logic [7:0]  Addr_Prog;
    logic [31:0] Data_Prog;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  words_loaded;

    int total = 0;
    int bad   = 0;

    mips_prog_loader #(
        .ADDR_W(8), .DATA_W(32), .RST_CYCLES(2), .TIMEOUT(50)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .load_req(load_req), .ProgMode(ProgMode),
        .Addr_Prog(Addr_Prog), .Data_Prog(Data_Prog), .core_reset(core_reset),
        .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        logic        rdy;
    } wr_t;

    wr_t        wq[$];
    logic [8:0] prev_wl = '0;
    logic       prev_rdy = 1'b0;

    // A write is seen when words_loaded steps by one; rdy is rx_ready in the commit cycle
    always @(negedge clk) begin
        if (reset && words_loaded == prev_wl + 9'd1)
            wq.push_back('{Addr_Prog, Data_Prog, prev_rdy});
        prev_wl  = words_loaded;
        prev_rdy = rx_ready;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx,
                          input logic [7:0] a, input logic [31:0] d);
        chk({tag, "_present"}, 64'(wq.size() > idx), 64'd1);
        if (wq.size() > idx) begin
            chk({tag, "_addr"}, 64'(wq[idx].a), 64'(a));
            chk({tag, "_data"}, 64'(wq[idx].d), 64'(d));
            chk({tag, "_rdy"}, 64'(wq[idx].rdy), 64'd0);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        logic ok;
        logic rdy;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            rdy = rx_ready;
            @(negedge clk);
            ok = rdy;
        end
        rx_valid = 1'b0;
        if (!ok) chk("send_stall", 64'(ok), 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send(w[8*i +: 8], gap);
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] iv;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        load_req = 1'b0;

        // reset values
        #12;
        chk("rst_progmode", 64'(ProgMode), 64'd0);
        chk("rst_addr", 64'(Addr_Prog), 64'd0);
        chk("rst_data", 64'(Data_Prog), 64'd0);
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_wl", 64'(words_loaded), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        chk("idle_core_reset", 64'(core_reset), 64'd1);

        // 1: two-word load then boot
        send(8'h02, 0);
        send_word(32'h10600DDE, 0);
        send_word(32'h00000004, 0);
        chk("t1_commit_rdy", 64'(rx_ready), 64'd0);
        chk("t1_commit_cr", 64'(core_reset), 64'd0);
        chk("t1_commit_addr", 64'(Addr_Prog), 64'd1);
        chk("t1_commit_data", 64'(Data_Prog), 64'h4);
        @(negedge clk);
        chk("t1_boot0_pm", 64'(ProgMode), 64'd1);
        chk("t1_boot0_cr", 64'(core_reset), 64'd1);
        @(negedge clk);
        chk("t1_boot1_cr", 64'(core_reset), 64'd1);
        chk("t1_boot1_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("t1_run_cr", 64'(core_reset), 64'd0);
        chk("t1_run_done", 64'(done), 64'd1);
        chk("t1_run_pm", 64'(ProgMode), 64'd1);
        chk("t1_run_wl", 64'(words_loaded), 64'd2);
        chk("t1_nwr", 64'(wq.size()), 64'd2);
        chk_wr("t1_w0", 0, 8'h00, 32'h10600DDE);
        chk_wr("t1_w1", 1, 8'h01, 32'h00000004);

        // 4: reload from RUN
        pulse_req();
        chk("t4_pm", 64'(ProgMode), 64'd0);
        chk("t4_cr", 64'(core_reset), 64'd1);
        chk("t4_done", 64'(done), 64'd0);
        wq.delete();
        send(8'h01, 0);
        send_word(32'hFC00000F, 0);
        repeat (3) @(negedge clk);
        chk("t4_done_again", 64'(done), 64'd1);
        chk("t4_addr", 64'(Addr_Prog), 64'd0);
        chk("t4_data", 64'(Data_Prog), 64'hFC00000F);
        chk("t4_wl", 64'(words_loaded), 64'd1);
        chk_wr("t4_w0", 0, 8'h00, 32'hFC00000F);

        // 2: throttled stream, same writes
        pulse_req();
        wq.delete();
        send(8'h02, 1);
        send_word(32'h10600DDE, 1);
        send_word(32'h00000004, 1);
        repeat (3) @(negedge clk);
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_nwr", 64'(wq.size()), 64'd2);
        chk_wr("t2_w0", 0, 8'h00, 32'h10600DDE);
        chk_wr("t2_w1", 1, 8'h01, 32'h00000004);

        // 3: timeout after a partial word
        pulse_req();
        send(8'h01, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        send(8'hCC, 0);
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t3_idle_cycles", 64'(n), 64'd50);
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_pm", 64'(ProgMode), 64'd0);
        chk("t3_cr_idle", 64'(core_reset), 64'd1);
        chk("t3_wl", 64'(words_loaded), 64'd0);
        chk("t3_data_held", 64'(Data_Prog), 64'h4);
        @(negedge clk);
        chk("t3_hdr_ready", 64'(rx_ready), 64'd1);
        chk("t3_err_sticky", 64'(err), 64'd1);
        pulse_req();
        chk("t3_err_clr", 64'(err), 64'd0);

        // 5: reset in the middle of word 3
        wq.delete();
        send(8'h05, 0);
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        send_word(32'h33333333, 0);
        send(8'h44, 0);
        send(8'h55, 0);
        #2 reset = 1'b0;
        #1;
        chk("t5_pm", 64'(ProgMode), 64'd0);
        chk("t5_addr", 64'(Addr_Prog), 64'd0);
        chk("t5_data", 64'(Data_Prog), 64'd0);
        chk("t5_cr", 64'(core_reset), 64'd1);
        chk("t5_rdy", 64'(rx_ready), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_wl", 64'(words_loaded), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_nwr", 64'(wq.size()), 64'd3);
        chk_wr("t5_w2", 2, 8'h02, 32'h33333333);

        // 6: header 00 loads 256 words
        wq.delete();
        send(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            send_word({iv, ~iv, 8'h5A, iv}, 0);
        end
        repeat (3) @(negedge clk);
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_wl", 64'(words_loaded), 64'd256);
        chk("t6_addr", 64'(Addr_Prog), 64'hFF);
        chk("t6_nwr", 64'(wq.size()), 64'd256);
        chk_wr("t6_w128", 128, 8'h80, 32'h807F5A80);
        chk_wr("t6_w255", 255, 8'hFF, 32'hFF005AFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
